// File: rtl/regdump_pkg.sv
// Shared types and constants for the register-file dump unit:
// FSM state encoding, bytes per register and 8N1 frame constants.
package regdump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_LOAD,
        ST_SEND,
        ST_CSUM,
        ST_FIN
    } state_e;

    localparam int unsigned BYTES_PER_REG = 4;

    localparam logic        START_BIT  = 1'b0;
    localparam logic        STOP_BIT   = 1'b1;
    localparam int unsigned FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter. Owns the bit timer and bit counter. A new byte may be
// loaded on the last cycle of a stop bit, so frames can run back to back.
module uart_tx_byte
    import regdump_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int unsigned     TW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0]   TLAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      BLAST = 4'(FRAME_BITS - 1);

    logic          active_q, active_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    bit_q, bit_d;
    logic [8:0]    frame_q, frame_d;
    logic          tx_q, tx_d;
    logic          bit_end;

    assign bit_end = (timer_q == TLAST);
    // Ready when idle or on the final cycle of the stop bit.
    assign ready   = !active_q || (bit_end && (bit_q == BLAST));
    assign tx      = tx_q;

    always_comb begin
        active_d = active_q;
        timer_d  = timer_q;
        bit_d    = bit_q;
        frame_d  = frame_q;
        tx_d     = tx_q;
        if (active_q) begin
            timer_d = bit_end ? '0 : timer_q + TW'(1);
            if (bit_end) begin
                if (bit_q == BLAST) begin
                    active_d = 1'b0;
                    tx_d     = STOP_BIT;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    tx_d    = frame_q[0];
                    frame_d = {STOP_BIT, frame_q[8:1]};
                end
            end
        end
        if (load && ready) begin
            active_d = 1'b1;
            timer_d  = '0;
            bit_d    = '0;
            tx_d     = START_BIT;
            frame_d  = {STOP_BIT, data};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q <= 1'b0;
            timer_q  <= '0;
            bit_q    <= '0;
            frame_q  <= '1;
            tx_q     <= 1'b1;
        end else begin
            active_q <= active_d;
            timer_q  <= timer_d;
            bit_q    <= bit_d;
            frame_q  <= frame_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: rtl/regfile_dump_uart.sv
// Walks register file x0..x(NUM_REGS-1) through a registered read port and sends
// each word MSB byte first over 8N1. Define REGDUMP_CHECKSUM_EN to append an XOR checksum byte.
module regfile_dump_uart
    import regdump_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned NUM_REGS     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  rf_addr,
    input  logic [31:0] rf_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned    IDX_W     = 5;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [2:0]     BYTE_LAST = 3'(BYTES_PER_REG);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      word_q, word_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef REGDUMP_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    logic       tx_load;
    logic [7:0] tx_byte;
    logic       tx_ready;

    assign rf_addr = idx_q;
    assign busy    = busy_q;
    assign done    = done_q;

    // Byte sequencing: first byte leaves straight from LOAD, the rest on ready.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tx_load = 1'b0;
        tx_byte = word_q[31:24];
`ifdef REGDUMP_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                    idx_d   = '0;
                    busy_d  = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            ST_READ: state_d = ST_LOAD;
            ST_LOAD: begin
                tx_load = 1'b1;
                tx_byte = rf_data[31:24];
                word_d  = {rf_data[23:0], 8'h00};
                cnt_d   = 3'd1;
                state_d = ST_SEND;
`ifdef REGDUMP_CHECKSUM_EN
                csum_d  = csum_q ^ rf_data[31:24];
`endif
            end
            ST_SEND: begin
                if (tx_ready) begin
                    if (cnt_q != BYTE_LAST) begin
                        tx_load = 1'b1;
                        word_d  = {word_q[23:0], 8'h00};
                        cnt_d   = cnt_q + 3'd1;
`ifdef REGDUMP_CHECKSUM_EN
                        csum_d  = csum_q ^ word_q[31:24];
`endif
                    end else if (idx_q < LAST_IDX) begin
                        idx_d   = idx_q + 5'd1;
                        state_d = ST_READ;
                    end else begin
`ifdef REGDUMP_CHECKSUM_EN
                        tx_load = 1'b1;
                        tx_byte = csum_q;
                        state_d = ST_CSUM;
`else
                        state_d = ST_FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            ST_CSUM: begin
                if (tx_ready) begin
                    state_d = ST_FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
`endif
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef REGDUMP_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk  (clk),
        .reset(reset),
        .load (tx_load),
        .data (tx_byte),
        .tx   (tx),
        .ready(tx_ready)
    );

endmodule

// File: tb/tb_regfile_dump_uart.sv
// Bench for regfile_dump_uart: records the serial line every cycle, decodes it
// into bytes and compares against bytes derived from the register contents.
module tb_regfile_dump_uart;

    localparam int CPB   = 4;
    localparam int NREGS = 2;
    localparam int FRAME = 10 * CPB;
`ifdef REGDUMP_CHECKSUM_EN
    localparam int CSUM_BYTES = 1;
`else
    localparam int CSUM_BYTES = 0;
`endif
    localparam int EXP_DONE = 3 + NREGS * 4 * FRAME + (NREGS - 1) * 2 + CSUM_BYTES * FRAME;

    typedef logic [7:0] bq_t [$];
    typedef struct {
        logic [31:0] x0;
        logic [31:0] x1;
        int          disturb;
        logic [63:0] exp_bytes;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        tx;
    logic        busy;
    logic        done;

    logic [31:0] rf [32];
    logic        trace_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    // Register file with a one-cycle registered read.
    always_ff @(posedge clk) rf_data <= rf[rf_addr];

    regfile_dump_uart #(
        .CLKS_PER_BIT(CPB),
        .NUM_REGS    (NREGS)
    ) dut (
        .clk    (clk),
        .reset  (rst_n),
        .start  (start),
        .rf_addr(rf_addr),
        .rf_data(rf_data),
        .tx     (tx),
        .busy   (busy),
        .done   (done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic bq_t with_csum(input bq_t q);
        bq_t r = q;
`ifdef REGDUMP_CHECKSUM_EN
        logic [7:0] x = 8'h00;
        foreach (q[i]) x = x ^ q[i];
        r.push_back(x);
`endif
        return r;
    endfunction

    function automatic bq_t model_bytes();
        bq_t q;
        for (int i = 0; i < NREGS; i++)
            for (int b = 3; b >= 0; b--) q.push_back(rf[i][8*b +: 8]);
        return with_csum(q);
    endfunction

    function automatic bq_t vec_bytes(input logic [63:0] v);
        bq_t q;
        for (int b = 0; b < 8; b++) q.push_back(v[63-8*b -: 8]);
        return with_csum(q);
    endfunction

    // One dump: record the line, then decode frames and inter-byte gaps.
    task automatic run_dump(input bq_t exp, input int disturb, input string tag);
        int         done_at;
        int         busy_err;
        int         limit;
        int         pos;
        int         gap;
        int         exp_gap;
        int         frame_err;
        int         gap_err;
        bq_t        got;
        logic [7:0] v;
        done_at   = 0;
        busy_err  = 0;
        frame_err = 0;
        gap_err   = 0;
        trace_q   = {};
        trace_q.push_back(1'b1);
        @(negedge clk);
        start = 1'b1;
        for (int j = 1; j <= 2 * EXP_DONE && done_at == 0; j++) begin
            @(negedge clk);
            start = (j == disturb);
            trace_q.push_back(tx);
            if (done) begin
                done_at = j;
                if (busy) busy_err++;
            end else if (!busy) begin
                busy_err++;
            end
        end
        start = 1'b0;
        check({tag, "/done_at"}, 64'(done_at), 64'(EXP_DONE));
        check({tag, "/busy_window"}, 64'(busy_err), 64'd0);
        @(negedge clk);
        check({tag, "/post_idle"}, {61'd0, done, busy, tx}, 64'd1);

        limit = (done_at > 0) ? done_at : trace_q.size();
        pos   = 1;
        gap   = 0;
        while (pos < limit) begin
            if (trace_q[pos]) begin
                gap++;
                pos++;
            end else if (pos + FRAME > limit) begin
                frame_err++;
                pos = limit;
            end else begin
                exp_gap = (got.size() == 0 || (got.size() % 4 == 0 && got.size() < 4 * NREGS)) ? 2 : 0;
                if (gap != exp_gap) gap_err++;
                for (int f = 0; f < 10; f++)
                    for (int s = 0; s < CPB; s++)
                        if (trace_q[pos + f*CPB + s] !== trace_q[pos + f*CPB]) frame_err++;
                if (trace_q[pos + 9*CPB] !== 1'b1) frame_err++;
                for (int b = 0; b < 8; b++) v[b] = trace_q[pos + (1 + b) * CPB];
                got.push_back(v);
                pos += FRAME;
                gap = 0;
            end
        end
        if (gap != 0) gap_err++;
        check({tag, "/framing"}, 64'(frame_err), 64'd0);
        check({tag, "/gaps"}, 64'(gap_err), 64'd0);
        check({tag, "/nbytes"}, 64'(got.size()), 64'(exp.size()));
        foreach (exp[i])
            if (i < got.size()) check($sformatf("%s/byte%0d", tag, i), 64'(got[i]), 64'(exp[i]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected end of test");
        $fatal(1);
    end

    initial begin
        vec_t        tv [6];
        int          errs;
        logic [9:0]  a5_line;
        tv[0] = '{32'h0000_0000, 32'h1234_5678, 0,        64'h00000000_12345678};
        tv[1] = '{32'h0000_00A5, 32'hFFFF_FFFF, 0,        64'h000000A5_FFFFFFFF};
        tv[2] = '{32'hDEAD_BEEF, 32'h0102_0304, 50,       64'hDEADBEEF_01020304};
        tv[3] = '{32'h8000_0001, 32'h7F00_FF00, 1,        64'h80000001_7F00FF00};
        tv[4] = '{32'hCAFE_F00D, 32'h0000_0000, 163,      64'hCAFEF00D_00000000};
        tv[5] = '{32'h5A5A_5A5A, 32'hC3C3_C3C3, EXP_DONE, 64'h5A5A5A5A_C3C3C3C3};
        a5_line = 10'b11_0100_1010;

        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rst_n = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("reset%0d/tx", c), 64'(tx), 64'd1);
            check($sformatf("reset%0d/busy", c), 64'(busy), 64'd0);
            check($sformatf("reset%0d/done", c), 64'(done), 64'd0);
            check($sformatf("reset%0d/rf_addr", c), 64'(rf_addr), 64'd0);
        end
        rst_n = 1'b1;
        start = 1'b0;
        errs  = 0;
        repeat (12) begin
            @(negedge clk);
            if (!tx || busy || done) errs++;
        end
        check("idle_after_reset", 64'(errs), 64'd0);

        for (int i = 0; i < 6; i++) begin
            rf[0] = tv[i].x0;
            rf[1] = tv[i].x1;
            run_dump(vec_bytes(tv[i].exp_bytes), tv[i].disturb, $sformatf("vec%0d", i));
        end

        // 0xA5 is the last byte of x0: it starts 3 bytes after the first start bit.
        rf[0] = 32'h0000_00A5;
        rf[1] = $urandom;
        run_dump(model_bytes(), 0, "a5");
        for (int f = 0; f < 10; f++)
            for (int s = 0; s < CPB; s++)
                if (3 + 3*FRAME + f*CPB + s < trace_q.size())
                    check($sformatf("a5/bit%0d_s%0d", f, s),
                          64'(trace_q[3 + 3*FRAME + f*CPB + s]), 64'(a5_line[f]));

        // Reset during the start bit of the third byte.
        rf[0] = 32'h0BAD_F00D;
        rf[1] = 32'h1357_9BDF;
        @(negedge clk);
        start = 1'b1;
        for (int j = 1; j <= 3 + 2*FRAME; j++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("midreset/pre_tx", 64'(tx), 64'd0);
        rst_n = 1'b0;
        #1;
        check("midreset/async_tx", 64'(tx), 64'd1);
        check("midreset/async_busy", 64'(busy), 64'd0);
        errs = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy || !tx) errs++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done || busy || !tx) errs++;
        end
        check("midreset/quiet", 64'(errs), 64'd0);
        rf[0] = tv[0].x0;
        rf[1] = tv[0].x1;
        run_dump(vec_bytes(tv[0].exp_bytes), 0, "after_reset");

        for (int r = 0; r < 6; r++) begin
            rf[0] = $urandom;
            rf[1] = $urandom;
            run_dump(model_bytes(), int'($urandom_range(0, EXP_DONE)), $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
